// File: rtl/tdm_demux.sv
// Time-division 1-to-N demultiplexer: reassembles a serial slot stream into an
// N-bit word, framed by a sync marker, with a one-cycle valid pulse per frame.
module tdm_demux #(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          din,
  input  logic          din_valid,
  input  logic          sync,
  output logic [N-1:0]  y,
  output logic          y_valid,
  output logic [SW-1:0] slot,
  output logic          locked,
  output logic          frame_err
);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_COLLECT = 1'b1
  } state_e;

  localparam logic [SW-1:0] LastSlot = SW'(N - 1);

  state_e        state_q;
  logic [N-1:0]  shadow_q;
  logic [N-1:0]  y_q;
  logic          y_valid_q;
  logic [SW-1:0] slot_q;
  logic          locked_q;
  logic          frame_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      shadow_q    <= '0;
      y_q         <= '0;
      y_valid_q   <= 1'b0;
      slot_q      <= '0;
      locked_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      // NOTE: pulses default low here; a later assignment in this block wins.
      y_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
      if (din_valid) begin
        unique case (state_q)
          S_IDLE: begin
            if (sync) begin
              state_q     <= S_COLLECT;
              locked_q    <= 1'b1;
              shadow_q[0] <= din;
              slot_q      <= SW'(1);
            end
          end
          S_COLLECT: begin
            if (sync) begin
              // sync always restarts the frame; only a partial frame is an error
              frame_err_q <= (slot_q != '0);
              shadow_q[0] <= din;
              slot_q      <= SW'(1);
            end else begin
              shadow_q[slot_q] <= din;
              if (slot_q == LastSlot) begin
                y_q       <= {din, shadow_q[N-2:0]};
                y_valid_q <= 1'b1;
                slot_q    <= '0;
              end else begin
                slot_q <= slot_q + SW'(1);
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign y         = y_q;
  assign y_valid   = y_valid_q;
  assign slot      = slot_q;
  assign locked    = locked_q;
  assign frame_err = frame_err_q;

endmodule
